// File: rtl/riscv_pkg.sv
// Shared pipeline package: widths, result-source and branch encodings,
// ALU flag bit positions and the EX/WB writeback FSM state type.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } ex_wb_state_t;

endpackage

// File: rtl/ex_wb_stage_if.sv
// EX->WB bundle: EX control/data in, redirect, data-memory port,
// writeback and forwarding out. master = upstream/memory, slave = stage.
interface ex_wb_stage_if;
  import riscv_pkg::*;

  logic               ex_valid;
  logic [XLEN-1:0]    ex_result;
  logic [3:0]         ex_flags;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_reg_write;
  logic [1:0]         ex_result_src;
  logic               ex_mem_write;
  logic [XLEN-1:0]    ex_write_data;
  logic               ex_branch;
  logic               ex_jump;
  logic [2:0]         ex_funct3;
  logic [XLEN-1:0]    ex_pc_plus4;
  logic [XLEN-1:0]    ex_pc_target;
  logic               ex_stall;
  logic               pc_src;
  logic [XLEN-1:0]    pc_target;
  logic [XLEN-1:0]    dmem_addr;
  logic [XLEN-1:0]    dmem_wdata;
  logic               dmem_we;
  logic               dmem_re;
  logic [XLEN-1:0]    dmem_rdata;
  logic               wb_we;
  logic [RADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_rd;
  logic [XLEN-1:0]    fwd_data;

  modport master (
    output ex_valid, ex_result, ex_flags, ex_rd,
    output ex_reg_write, ex_result_src, ex_mem_write,
    output ex_write_data, ex_branch, ex_jump, ex_funct3,
    output ex_pc_plus4, ex_pc_target, dmem_rdata,
    input  ex_stall, pc_src, pc_target,
    input  dmem_addr, dmem_wdata, dmem_we, dmem_re,
    input  wb_we, wb_rd, wb_data,
    input  fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  ex_valid, ex_result, ex_flags, ex_rd,
    input  ex_reg_write, ex_result_src, ex_mem_write,
    input  ex_write_data, ex_branch, ex_jump, ex_funct3,
    input  ex_pc_plus4, ex_pc_target, dmem_rdata,
    output ex_stall, pc_src, pc_target,
    output dmem_addr, dmem_wdata, dmem_we, dmem_re,
    output wb_we, wb_rd, wb_data,
    output fwd_valid, fwd_rd, fwd_data
  );

endinterface

// File: rtl/branch_resolve.sv
// Branch condition from funct3 and ALU {N,Z,C,V} after SUB.
// Ports: i_funct3, i_flags in; o_taken out (combinational).
module branch_resolve
  import riscv_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [3:0] i_flags,
  output logic       o_taken
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  // C=1 means A>=B unsigned (SUB is A+~B+1)
  always_comb begin
    o_taken = 1'b0;
    unique case (i_funct3)
      BR_BEQ:  o_taken = w_z;
      BR_BNE:  o_taken = ~w_z;
      BR_BLT:  o_taken = w_n ^ w_v;
      BR_BGE:  o_taken = ~(w_n ^ w_v);
      BR_BLTU: o_taken = ~w_c;
      BR_BGEU: o_taken = w_c;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// EX/WB back end: branch redirect, data-memory strobes, registered
// writeback, one-cycle load stall. Ports: clk, rst, bus (ex_wb_stage_if.slave).
// Optional macro EX_WB_FWD_EN drives the fwd_* bypass outputs.
module ex_wb_stage
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  ex_wb_stage_if.slave bus
);

  ex_wb_state_t       r_state;
  logic               r_wb_we;
  logic [RADDR_W-1:0] r_wb_rd;
  logic [XLEN-1:0]    r_wb_data;
  logic               r_ld_we;
  logic [RADDR_W-1:0] r_ld_rd;

  logic               w_idle;
  logic               w_accept;
  logic               w_load;
  logic               w_wr;
  logic               w_taken;
  logic [XLEN-1:0]    w_wb_val;

  branch_resolve u_br (
    .i_funct3 (bus.ex_funct3),
    .i_flags  (bus.ex_flags),
    .o_taken  (w_taken)
  );

  assign w_idle   = (r_state == IDLE);
  // strobes are gated low while reset is held
  assign w_accept = bus.ex_valid & w_idle & ~rst;
  assign w_load   = (bus.ex_result_src == RESULT_SRC_MEM);
  assign w_wr     = bus.ex_reg_write & (bus.ex_rd != '0);
  assign w_wb_val = (bus.ex_result_src == RESULT_SRC_PC4)
                  ? bus.ex_pc_plus4 : bus.ex_result;

  assign bus.ex_stall   = (r_state == LOAD_WAIT);
  assign bus.pc_src     = w_accept
                        & (bus.ex_jump | (bus.ex_branch & w_taken));
  assign bus.pc_target  = bus.ex_pc_target;
  assign bus.dmem_addr  = bus.ex_result;
  assign bus.dmem_wdata = bus.ex_write_data;
  assign bus.dmem_we    = w_accept & bus.ex_mem_write;
  assign bus.dmem_re    = w_accept & w_load;

  assign bus.wb_we   = r_wb_we;
  assign bus.wb_rd   = r_wb_rd;
  assign bus.wb_data = r_wb_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_ld_we   <= 1'b0;
      r_ld_rd   <= '0;
    end else begin
      r_wb_we <= 1'b0;
      unique case (r_state)
        LOAD_WAIT: begin
          r_state <= IDLE;
          r_wb_we <= r_ld_we;
          if (r_ld_we) begin
            r_wb_rd   <= r_ld_rd;
            r_wb_data <= bus.dmem_rdata;
          end
        end
        default: begin
          if (w_accept && w_load) begin
            r_state <= LOAD_WAIT;
            r_ld_we <= w_wr;
            r_ld_rd <= bus.ex_rd;
          end else if (w_accept) begin
            r_wb_we <= w_wr;
            if (w_wr) begin
              r_wb_rd   <= bus.ex_rd;
              r_wb_data <= w_wb_val;
            end
          end
        end
      endcase
    end
  end

`ifdef EX_WB_FWD_EN
  // bypass entry is not usable while a load is still in flight
  assign bus.fwd_valid = r_wb_we & w_idle;
  assign bus.fwd_rd    = r_wb_rd;
  assign bus.fwd_data  = r_wb_data;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_rd    = '0;
  assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: cycle model plus literal checks.
// Model tracks a pending load and the architectural writeback.
module tb_ex_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_wb_stage_if bus ();

  ex_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state
  bit          m_pend;
  bit          m_ld_we;
  logic [4:0]  m_ld_rd;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond(input logic [2:0] f3,
                              input logic [3:0] fl);
    bit n, z, c, v;
    {n, z, c, v} = fl;
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n != v;
      3'd5: return n == v;
      3'd6: return !c;
      3'd7: return c;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_we = 0; m_rd = 0; m_data = 0; m_ld_we = 0;
    end else if (m_pend) begin
      m_pend = 0;
      m_we = m_ld_we;
      if (m_we) begin
        m_rd = m_ld_rd;
        m_data = bus.dmem_rdata;
      end
    end else if (bus.ex_valid) begin
      if (bus.ex_result_src == 2'b01) begin
        m_pend = 1;
        m_we = 0;
        m_ld_we = bus.ex_reg_write && bus.ex_rd != 0;
        m_ld_rd = bus.ex_rd;
      end else begin
        m_we = bus.ex_reg_write && bus.ex_rd != 0;
        if (m_we) begin
          m_rd = bus.ex_rd;
          m_data = (bus.ex_result_src == 2'b10)
                 ? bus.ex_pc_plus4 : bus.ex_result;
        end
      end
    end else begin
      m_we = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit acc;
      acc = bus.ex_valid && !m_pend && !rst;
      chk("m_stall", bus.ex_stall, m_pend);
      chk("m_pc_src", bus.pc_src, acc && (bus.ex_jump ||
          (bus.ex_branch && cond(bus.ex_funct3, bus.ex_flags))));
      chk("m_pc_target", bus.pc_target, bus.ex_pc_target);
      chk("m_dmem_re", bus.dmem_re, acc && bus.ex_result_src == 2'b01);
      chk("m_dmem_we", bus.dmem_we, acc && bus.ex_mem_write);
      chk("m_dmem_addr", bus.dmem_addr, bus.ex_result);
      chk("m_dmem_wdata", bus.dmem_wdata, bus.ex_write_data);
      chk("m_wb_we", bus.wb_we, m_we);
      chk("m_wb_rd", bus.wb_rd, m_rd);
      chk("m_wb_data", bus.wb_data, m_data);
`ifdef EX_WB_FWD_EN
      chk("m_fwd_valid", bus.fwd_valid, m_we && !m_pend);
      chk("m_fwd_rd", bus.fwd_rd, m_rd);
      chk("m_fwd_data", bus.fwd_data, m_data);
`else
      chk("m_fwd_valid", bus.fwd_valid, 0);
      chk("m_fwd_rd", bus.fwd_rd, 0);
      chk("m_fwd_data", bus.fwd_data, 0);
`endif
    end
  end

  task automatic idle();
    bus.ex_valid = 0; bus.ex_result = 0; bus.ex_flags = 0;
    bus.ex_rd = 0; bus.ex_reg_write = 0; bus.ex_result_src = 0;
    bus.ex_mem_write = 0; bus.ex_write_data = 0;
    bus.ex_branch = 0; bus.ex_jump = 0; bus.ex_funct3 = 0;
    bus.ex_pc_plus4 = 32'h1004; bus.ex_pc_target = 32'h2000;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res,
                     input logic [1:0] src);
    idle();
    bus.ex_valid = 1; bus.ex_rd = rd; bus.ex_reg_write = 1;
    bus.ex_result = res; bus.ex_result_src = src;
  endtask

  task automatic br(input logic [2:0] f3, input logic [3:0] fl);
    idle();
    bus.ex_valid = 1; bus.ex_branch = 1;
    bus.ex_funct3 = f3; bus.ex_flags = fl;
    bus.ex_pc_target = 32'h0000_0200;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    idle();
    bus.dmem_rdata = 32'h0;
    rst = 1;
    step(); step();
    chk_en = 1;
    at_neg();
    chk("rst_wb_we", bus.wb_we, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_stall", bus.ex_stall, 0);
    step();
    rst = 0;

    // ADD x3 = 5
    alu(5'd3, 32'h5, 2'b00);
    at_neg();
    chk("add_stall", bus.ex_stall, 0);
    step(); idle();
    at_neg();
    chk("add_wb_we", bus.wb_we, 1);
    chk("add_wb_rd", bus.wb_rd, 3);
    chk("add_wb_data", bus.wb_data, 32'h5);
    step();

    // LW x5 <- [0x100], then ADD x6 = 7 held behind it
    alu(5'd5, 32'h100, 2'b01);
    bus.dmem_rdata = 32'hDEAD_BEEF;
    at_neg();
    chk("lw_re_T", bus.dmem_re, 1);
    chk("lw_addr", bus.dmem_addr, 32'h100);
    step();
    alu(5'd6, 32'h7, 2'b00);
    at_neg();
    chk("lw_stall_T1", bus.ex_stall, 1);
    chk("lw_re_T1", bus.dmem_re, 0);
    step();
    bus.dmem_rdata = 32'h0;
    at_neg();
    chk("lw_wb_we", bus.wb_we, 1);
    chk("lw_wb_rd", bus.wb_rd, 5);
    chk("lw_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("lw_stall_T2", bus.ex_stall, 0);
    step(); idle();
    at_neg();
    chk("held_wb_rd", bus.wb_rd, 6);
    chk("held_wb_data", bus.wb_data, 32'h7);
    step();

    // branch sweep
    br(3'b000, 4'b0100);
    at_neg();
    chk("beq_taken", bus.pc_src, 1);
    chk("beq_target", bus.pc_target, 32'h200);
    step();
    br(3'b100, 4'b1001);
    at_neg();
    chk("blt_nv", bus.pc_src, 0);
    step();
    br(3'b111, 4'b0010);
    at_neg();
    chk("bgeu_c", bus.pc_src, 1);
    step();
    br(3'b010, 4'b1111);
    at_neg();
    chk("f3_010", bus.pc_src, 0);
    step();
    br(3'b001, 4'b0100);
    step();
    br(3'b101, 4'b1000);
    step();
    br(3'b110, 4'b0000);
    step();
    idle();
    bus.ex_valid = 1; bus.ex_jump = 1;
    at_neg();
    chk("jal_taken", bus.pc_src, 1);
    step();

    // store, rd=0
    idle();
    bus.ex_valid = 1; bus.ex_mem_write = 1;
    bus.ex_result = 32'h40; bus.ex_write_data = 32'h1234;
    at_neg();
    chk("st_we", bus.dmem_we, 1);
    chk("st_wdata", bus.dmem_wdata, 32'h1234);
    step(); idle();
    at_neg();
    chk("st_no_wb", bus.wb_we, 0);
    chk("st_we_once", bus.dmem_we, 0);
    step();

    // write to x0
    alu(5'd0, 32'h9, 2'b00);
    step(); idle();
    at_neg();
    chk("x0_no_wb", bus.wb_we, 0);
    step();

    // PC+4 and reserved source
    alu(5'd7, 32'h55, 2'b10);
    step();
    alu(5'd8, 32'h66, 2'b11);
    at_neg();
    chk("pc4_data", bus.wb_data, 32'h1004);
    step(); idle();
    at_neg();
    chk("rsv_data", bus.wb_data, 32'h66);
    step();

    // reset during LOAD_WAIT
    alu(5'd9, 32'h180, 2'b01);
    bus.dmem_rdata = 32'hCAFE_F00D;
    step();
    idle();
    rst = 1;
    at_neg();
    chk("rlw_stall_in", bus.ex_stall, 1);
    step();
    rst = 0;
    at_neg();
    chk("rlw_stall", bus.ex_stall, 0);
    chk("rlw_wb_we", bus.wb_we, 0);
    step();
    at_neg();
    chk("rlw_wb_we2", bus.wb_we, 0);
    step();

    // valid-low gaps between writes
    alu(5'd10, 32'hA5A5_0001, 2'b00);
    step(); idle();
    step();
    at_neg();
    chk("gap_hold_data", bus.wb_data, 32'hA5A5_0001);
    chk("gap_we_low", bus.wb_we, 0);
    step();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
